// File: rtl/snake_pkg.sv
// Shared definitions for the snake body controller: grid limits, direction and
// state encodings, and the power-on body layout.
package snake_pkg;

    localparam int unsigned GRID_MIN = 1;
    localparam int unsigned GRID_MAX = 15;
    localparam int unsigned MAX_LEN  = 16;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_WAIT_START,
        ST_RUN,
        ST_OVER
    } state_t;

    localparam logic [7:0] RST_SEG0 = {4'd3, 4'd8};
    localparam logic [7:0] RST_SEG1 = {4'd2, 4'd8};
    localparam logic [7:0] RST_SEG2 = {4'd1, 4'd8};

    // Encodings pair up/down and left/right on bit 0, so flipping it gives the reverse.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Key_dir is {up,down,left,right}; callers qualify one-hotness separately.
    function automatic dir_t key_to_dir(input logic [3:0] key);
        if (key[3])      return DIR_UP;
        else if (key[2]) return DIR_DOWN;
        else if (key[1]) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

    function automatic logic [7:0] reset_seg(input int unsigned idx);
        case (idx)
            0:       return RST_SEG0;
            1:       return RST_SEG1;
            2:       return RST_SEG2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Free-running move timer: counts 0..STEP_CYCLES-1 while enabled and flags the
// terminal count; clear forces it back to 0.
module snake_step_timer #(
    parameter int unsigned STEP_CYCLES = 12000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tc = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: direction capture, timed head moves with wall/self
// collision detection, growth on request, and a sticky game-over state.
module snake_body_ctrl #(
    parameter int unsigned STEP_CYCLES = 12000000,
    parameter int unsigned MAX_LEN     = snake_pkg::MAX_LEN
) (
    input  logic                 Clk_24mhz,
    input  logic                 Rst_n,
    input  logic [3:0]           Key_dir,
    input  logic                 Body_add_sig,
    output logic [7:0]           Head,
    output logic [8*MAX_LEN-1:0] Body_flat,
    output logic [4:0]           Body_len,
    output logic                 Step_sig,
    output logic                 Game_over
);

    import snake_pkg::*;

    state_t     r_state;
    dir_t       r_dir;
    dir_t       r_dir_pend;
    logic       r_grow;
    logic [7:0] r_seg [MAX_LEN];
    logic [4:0] r_len;
    logic       r_step;
    logic       r_over;

    logic       w_tc;
    dir_t       w_key_dir;
    logic       w_key_valid;
    dir_t       w_dir_next;
    logic       w_grow;
    logic [3:0] w_nx;
    logic [3:0] w_ny;
    logic [7:0] w_next_head;
    logic       w_wall;
    logic       w_self;
    logic       w_hit;
    logic [4:0] w_new_len;

    snake_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .i_clk  (Clk_24mhz),
        .i_rst_n(Rst_n),
        .i_en   (r_state == ST_RUN),
        .i_clr  (r_state == ST_WAIT_START),
        .o_tc   (w_tc)
    );

    // A key or grow request arriving on the step-event cycle still applies to that step.
    assign w_key_dir   = key_to_dir(Key_dir);
    assign w_key_valid = $onehot(Key_dir) && (w_key_dir != opposite(r_dir));
    assign w_dir_next  = w_key_valid ? w_key_dir : r_dir_pend;
    assign w_grow      = r_grow || Body_add_sig;
    assign w_new_len   = (w_grow && (32'(r_len) < MAX_LEN)) ? r_len + 5'd1 : r_len;

    always_comb begin
        w_nx = r_seg[0][7:4];
        w_ny = r_seg[0][3:0];
        case (w_dir_next)
            DIR_UP:    w_ny = r_seg[0][3:0] - 4'd1;
            DIR_DOWN:  w_ny = r_seg[0][3:0] + 4'd1;
            DIR_LEFT:  w_nx = r_seg[0][7:4] - 4'd1;
            DIR_RIGHT: w_nx = r_seg[0][7:4] + 4'd1;
        endcase
    end

    assign w_next_head = {w_nx, w_ny};
    assign w_wall      = (32'(w_nx) < GRID_MIN) || (32'(w_ny) < GRID_MIN);

    // The tail only counts as an obstacle when it will not vacate this step.
    always_comb begin
        w_self = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (((i + 2 <= 32'(r_len)) || (w_grow && (i + 1 <= 32'(r_len))))
                && (r_seg[i] == w_next_head)) begin
                w_self = 1'b1;
            end
        end
    end

    assign w_hit = w_wall || w_self;

    always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= ST_WAIT_START;
            r_dir      <= DIR_RIGHT;
            r_dir_pend <= DIR_RIGHT;
            r_grow     <= 1'b0;
            r_len      <= 5'd3;
            r_step     <= 1'b0;
            r_over     <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                r_seg[i] <= reset_seg(i);
            end
        end else begin
            r_step <= 1'b0;
            case (r_state)
                ST_WAIT_START: begin
                    if (w_key_valid) begin
                        r_dir_pend <= w_key_dir;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_key_valid) r_dir_pend <= w_key_dir;
                    if (Body_add_sig) r_grow <= 1'b1;
                    if (w_tc) begin
                        if (w_hit) begin
                            r_over  <= 1'b1;
                            r_state <= ST_OVER;
                        end else begin
                            r_dir    <= w_dir_next;
                            r_grow   <= 1'b0;
                            r_len    <= w_new_len;
                            r_step   <= 1'b1;
                            r_seg[0] <= w_next_head;
                            for (int unsigned i = 1; i < MAX_LEN; i++) begin
                                r_seg[i] <= (i < 32'(w_new_len)) ? r_seg[i-1] : '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Body_flat = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            Body_flat[8*i +: 8] = r_seg[i];
        end
    end

    assign Head      = r_seg[0];
    assign Body_len  = r_len;
    assign Step_sig  = r_step;
    assign Game_over = r_over;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: queue-based snake model compared every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_snake_body_ctrl;

    localparam int unsigned SC = 4;
    localparam int unsigned ML = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      key;
    logic            add;
    logic [7:0]      head;
    logic [8*ML-1:0] flat;
    logic [4:0]      len;
    logic            step;
    logic            over;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    snake_body_ctrl #(
        .STEP_CYCLES(SC),
        .MAX_LEN    (ML)
    ) dut (
        .Clk_24mhz   (clk),
        .Rst_n       (rst_n),
        .Key_dir     (key),
        .Body_add_sig(add),
        .Head        (head),
        .Body_flat   (flat),
        .Body_len    (len),
        .Step_sig    (step),
        .Game_over   (over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase;   // 0 waiting, 1 running, 2 over
    int         m_cnt;
    int         m_dir;     // 0 up, 1 down, 2 left, 3 right
    int         m_pend;
    bit         m_grow;
    bit         m_step;
    bit         m_over;
    logic [7:0] m_body[$];

    function automatic void model_reset();
        m_phase = 0; m_cnt = 0; m_dir = 3; m_pend = 3;
        m_grow = 0; m_step = 0; m_over = 0;
        m_body = '{8'h38, 8'h28, 8'h18};
    endfunction

    function automatic int key2dir(input logic [3:0] k);
        for (int b = 0; b < 4; b++) if (k[b]) return 3 - b;
        return -1;
    endfunction

    function automatic void model_move();
        logic [7:0] h;
        logic [3:0] nx, ny;
        bit hit;
        h = m_body[0];
        nx = h[7:4];
        ny = h[3:0];
        case (m_pend)
            0: ny = ny - 4'd1;
            1: ny = ny + 4'd1;
            2: nx = nx - 4'd1;
            default: nx = nx + 4'd1;
        endcase
        hit = (nx == 0) || (ny == 0);
        for (int i = 1; i < m_body.size(); i++)
            if ((i <= m_body.size() - 2 || (m_grow && i <= m_body.size() - 1)) && m_body[i] == {nx, ny})
                hit = 1;
        if (hit) begin
            m_phase = 2;
            m_over = 1;
        end else begin
            m_body.push_front({nx, ny});
            if (!(m_grow && m_body.size() - 1 < ML)) void'(m_body.pop_back());
            m_dir = m_pend;
            m_grow = 0;
            m_step = 1;
        end
    endfunction

    function automatic void model_tick();
        bit valid;
        m_step = 0;
        valid = ($countones(key) == 1) && (key2dir(key) != (m_dir ^ 1));
        if (m_phase == 0) begin
            if (valid) begin
                m_phase = 1; m_cnt = 0; m_pend = key2dir(key);
            end
        end else if (m_phase == 1) begin
            if (valid) m_pend = key2dir(key);
            if (add) m_grow = 1;
            if (m_cnt == SC - 1) begin
                m_cnt = 0;
                model_move();
            end else begin
                m_cnt++;
            end
        end
    endfunction

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < m_body.size(); i++) f[8*i +: 8] = m_body[i];
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_tick();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_head", head, m_body[0]);
            chk("cyc_flat", flat, m_flat());
            chk("cyc_len", len, m_body.size());
            chk("cyc_step", step, m_step);
            chk("cyc_over", over, m_over);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic [3:0] k, input logic a);
        key = k;
        add = a;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_head"}, head, 8'h38);
        chk({nm, "_flat"}, flat, 128'h182838);
        chk({nm, "_len"}, len, 5'd3);
        chk({nm, "_step"}, step, 1'b0);
        chk({nm, "_over"}, over, 1'b0);
    endtask

    task automatic do_reset(input string nm);
        #2 rst_n = 1'b0;
        #1 chk_reset(nm);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_step(input string nm);
        int n = 0;
        do begin
            tick(4'b0000, 1'b0);
            n++;
        end while (!step && n < 3 * SC);
        chk(nm, step, 1'b1);
    endtask

    task automatic wait_over(input string nm);
        int n = 0;
        do begin
            tick(4'b0000, 1'b0);
            n++;
        end while (!over && n < 3 * SC);
        chk(nm, over, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int oc;
        int r;
        logic [3:0] k;

        rst_n = 1'b0;
        key   = 4'b0000;
        add   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Start with right, first move after four cycles.
        tick(4'b0001, 1'b0);
        repeat (3) tick(4'b0000, 1'b0);
        chk("pre_step_head", head, 8'h38);
        tick(4'b0000, 1'b0);
        chk("first_step_head", head, 8'h48);
        chk("model_first_head", m_body[0], 8'h48);
        chk("first_step_pulse", step, 1'b1);
        chk("first_step_len", len, 5'd3);
        tick(4'b0000, 1'b0);
        chk("first_step_pulse_end", step, 1'b0);

        // Left is reversal and ignored; up takes effect at the next step.
        tick(4'b0010, 1'b0);
        tick(4'b1000, 1'b0);
        wait_step("up_step_seen");
        chk("up_head", head, 8'h47);

        // Two grow pulses in one period give a single growth.
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        wait_step("grow_step_seen");
        chk("grow_len", len, 5'd4);
        chk("grow_body", flat[31:0], 32'h38484746);
        wait_step("post_grow_step_seen");
        chk("post_grow_len", len, 5'd4);
        chk("post_grow_head", head, 8'h45);

        do_reset("rst_run");
        repeat (6) tick(4'b0000, 1'b0);
        chk("idle_after_reset_head", head, 8'h38);

        // Wall collision on the right edge.
        tick(4'b0001, 1'b0);
        for (int i = 0; i < 12; i++) wait_step("wall_run_step");
        chk("wall_edge_head", head, 8'hF8);
        wait_over("wall_over_seen");
        chk("wall_head_frozen", head, 8'hF8);
        chk("wall_len", len, 5'd3);
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(4'b1000 >> (i % 4), 1'b1);
            sc += int'(step);
        end
        chk("over_no_step", sc, 0);
        chk("over_head_held", head, 8'hF8);
        chk("over_sticky", over, 1'b1);

        // Self collision after growing to five and turning up, left, down.
        do_reset("rst_over");
        tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b1);
        wait_step("self_grow1");
        tick(4'b0000, 1'b1);
        wait_step("self_grow2");
        chk("self_len5", len, 5'd5);
        chk("self_body5", flat[39:0], 40'h1828384858);
        tick(4'b1000, 1'b0);
        wait_step("self_up");
        chk("self_up_head", head, 8'h57);
        tick(4'b0010, 1'b0);
        wait_step("self_left");
        chk("self_left_head", head, 8'h47);
        tick(4'b0100, 1'b0);
        wait_over("self_over_seen");
        chk("self_head_frozen", head, 8'h47);
        chk("self_body_frozen", flat[39:0], 40'h3848585747);
        do_reset("rst_after_self");

        // Randomized play against the model.
        oc = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      k = 4'b0000;
            else if (r < 8) k = 4'b0001 << $urandom_range(0, 3);
            else            k = 4'($urandom_range(0, 15));
            tick(k, ($urandom_range(0, 3) == 0));
            if (over) oc++;
            if (oc > 4 || $urandom_range(0, 299) == 0) begin
                do_reset("rst_rand");
                oc = 0;
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_body_ctrl.md
SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 12000000: clock cycles per snake move (0.5 s at 24 MHz).
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum body segments, head included.
REQ-003 SHALL have port Clk_24mhz, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port Key_dir, input, 4: one-hot direction request {up,down,left,right}, sampled every cycle.
REQ-006 SHALL have port Body_add_sig, input, 1: grow request pulse from the apple generator.
REQ-007 SHALL have port Head, output, 8: head coordinate {x[7:4], y[3:0]}, fed to the apple generator.
REQ-008 SHALL have port Body_flat, output, 8*MAX_LEN: segment i at [8i+7:8i]; segment 0 is the head.
REQ-009 SHALL have port Body_len, output, 5: current segment count, 3..MAX_LEN.
REQ-010 SHALL have port Step_sig, output, 1: one-cycle pulse on the cycle a move commits.
REQ-011 SHALL have port Game_over, output, 1: sticky collision flag.

Function
REQ-012 SHALL implement states WAIT_START, RUN, OVER; reset enters WAIT_START.
REQ-013 WAIT_START -> RUN on the first cycle Key_dir is a valid one-hot value that is not "left"; step counter starts at 0 on entry to RUN.
REQ-014 In RUN, the step counter SHALL count 0..STEP_CYCLES-1 and wrap; the terminal count is the step event.
REQ-015 Valid key = exactly one bit set and not opposite the current committed direction; invalid keys ignored; latest valid key stored as pending direction, committed at the next step.
REQ-016 At a step, next head = head moved one cell (up: y-1, down: y+1, left: x-1, right: x+1), 4-bit wrap arithmetic.
REQ-017 Playfield is 1..15 on both axes; a next-head x or y of 0 (overflow past 15 or underflow past 1) is a wall collision.
REQ-018 Self collision: next head equals segment i for 1 <= i <= Body_len-2 (tail vacates), or i <= Body_len-1 when growth is pending.
REQ-019 On any collision: no shift, Step_sig stays 0, Game_over <= 1, state -> OVER.
REQ-020 On a non-colliding step: seg[i] <= seg[i-1] for i >= 1, seg[0] <= next head, Step_sig = 1 for that one cycle; Head and Step_sig change in the cycle after terminal count.
REQ-021 Body_add_sig high in any RUN cycle sets grow_pending; several pulses before one step yield one growth; a pulse on the step-event cycle applies to that step.
REQ-022 At a step with grow_pending: Body_len += 1 (saturating at MAX_LEN, tail then discarded as normal), grow_pending cleared.
REQ-023 Segments with index >= Body_len SHALL drive 8'h00.
REQ-024 OVER is terminal until reset: counter halted, Key_dir and Body_add_sig ignored, outputs frozen.

Reset
REQ-025 Reset values: Head = {4'd3,4'd8}; segments 1,2 = {2,8},{1,8}; others 0; Body_len = 3; direction right; grow_pending 0; Step_sig 0; Game_over 0; counter 0.
REQ-026 Reset mid-RUN or in OVER SHALL restore all of REQ-025 immediately and asynchronously.

Structure
REQ-027 Package snake_pkg SHALL hold GRID_MIN=1, GRID_MAX=15, MAX_LEN, the direction encoding, and the reset segment coordinates.
REQ-028 The step counter SHALL be a sub-module snake_step_timer (enable, clear, terminal-count pulse out).

Verification (STEP_CYCLES=4)
REQ-029 Reset, Key_dir=0001 one cycle -> RUN; after 4 cycles Head={4,8}, Step_sig pulses once, Body_len=3.
REQ-030 Heading right, Key_dir=0010 (left) -> ignored; Key_dir=1000 then step -> Head y decrements, e.g. {4,8} -> {4,7}.
REQ-031 Body_add_sig pulse twice between steps -> next step Body_len 3->4, old tail retained; following step Body_len stays 4.
REQ-032 Drive right from {3,8} -> Head reaches {15,8}; next step Game_over=1, Head stays {15,8}, no further Step_sig.
REQ-033 Grow to length 5, turn up, left, down in successive steps -> head meets body, Game_over=1 at that step.
REQ-034 Assert Rst_n=0 mid-step while in RUN and in OVER -> all outputs at REQ-025 values in the same cycle, state WAIT_START.
